// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and defaults for the Morse reader blocks
package morse_pkg;

  // Width of the press-duration tick count shared with the tick generator.
  localparam int TICK_W = 17;

  localparam int CLK_F_DEF           = 25000000;
  localparam int TICK_RATE_DEF       = 9600;
  localparam int MIN_PRESS_TICKS_DEF = 96;
  localparam int DASH_TICKS_DEF      = 2400;
  localparam int GAP_TICKS_DEF       = 7200;
  localparam int MAX_SYMBOLS_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Clock cycles per tick; never below one so a prescaler can always wrap.
  function automatic int tick_div(input int clk_f, input int tick_rate);
    int d;
    d = clk_f / tick_rate;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/morse_symbol_decoder_tick_prescaler.sv
// rtl/morse_symbol_decoder_tick_prescaler.sv - free-running 0..DIV-1 divider with wrap pulse
module tick_prescaler #(
  parameter int DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The wrap pulse is not gated by clear, so a caller can act on a wrap
  // that coincides with its own restart request.
  assign tick = (cnt_q == LAST);

  // Next count: restart on clear, otherwise wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// rtl/morse_symbol_decoder.sv - classifies presses into dots/dashes and groups them into letters
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int CLK_F           = CLK_F_DEF,
  parameter int TICK_RATE       = TICK_RATE_DEF,
  parameter int MIN_PRESS_TICKS = MIN_PRESS_TICKS_DEF,
  parameter int DASH_TICKS      = DASH_TICKS_DEF,
  parameter int GAP_TICKS       = GAP_TICKS_DEF,
  parameter int MAX_SYMBOLS     = MAX_SYMBOLS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TICK_W-1:0] ticks,
  output logic              symbol_valid,
  output logic              symbol_is_dash,
  output logic              letter_valid,
  output logic [2:0]        letter_len,
  output logic [4:0]        letter_bits,
  output logic              letter_overflow
);

  localparam int DIV = tick_div(CLK_F, TICK_RATE);
  localparam int GW  = $clog2(GAP_TICKS + 1);

  localparam logic [TICK_W-1:0] MIN_T    = TICK_W'(MIN_PRESS_TICKS);
  localparam logic [TICK_W-1:0] DASH_T   = TICK_W'(DASH_TICKS);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_TICKS - 1);
  localparam logic [2:0]        MAX_CNT  = 3'(MAX_SYMBOLS);

  // Button synchroniser and edge detection.
  logic sync1_q;
  logic start_s_q;
  logic start_prev_q;
  logic rise;
  logic fall;

  state_e state_q;
  state_e state_d;

  logic [TICK_W-1:0] hold_q;
  logic [TICK_W-1:0] hold_d;
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_d;
  logic [4:0]        bits_q;
  logic [4:0]        bits_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [GW-1:0]     gap_q;
  logic [GW-1:0]     gap_d;

  logic       sym_valid_q;
  logic       sym_dash_q;
  logic       let_valid_q;
  logic [2:0] let_len_q;
  logic [4:0] let_bits_q;
  logic       let_ovf_q;

  // Decoded events driven by the output process.
  logic press_short;
  logic press_dash;
  logic accept;
  logic drop;
  logic reach;
  logic hold_clr;
  logic presc_clr;
  logic gap_tick;

  assign rise = start_s_q & ~start_prev_q;
  assign fall = ~start_s_q & start_prev_q;

  tick_prescaler #(
    .DIV (DIV)
  ) u_gap_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clr),
    .tick  (gap_tick)
  );

  // Two-flop synchroniser plus the previous synchronised level for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      start_s_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      sync1_q      <= start;
      start_s_q    <= sync1_q;
      start_prev_q <= start_s_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a letter closing together with a new press still
  // heads straight to PRESS because the letter is emitted in that same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (fall) begin
          if (press_short && (cnt_q == 3'd0)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d = ST_PRESS;
        end else if (reach) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/event decode for the current state.
  always_comb begin
    press_short = (hold_q < MIN_T);
    press_dash  = (hold_q >= DASH_T);
    accept      = 1'b0;
    drop        = 1'b0;
    reach       = 1'b0;
    hold_clr    = 1'b0;
    presc_clr   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        hold_clr = rise;
      end
      ST_PRESS: begin
        accept = fall && !press_short && (cnt_q < MAX_CNT);
        drop   = fall && !press_short && (cnt_q >= MAX_CNT);
      end
      ST_GAP: begin
        hold_clr  = rise;
        presc_clr = rise;
        reach     = gap_tick && (gap_q == GAP_LAST);
      end
      default: ;
    endcase
  end

  // Datapath next values: held press length, gap counter and the letter being built.
  always_comb begin
    hold_d = hold_q;
    if (start_s_q && (ticks != '0)) begin
      hold_d = ticks;
    end else if (hold_clr) begin
      hold_d = '0;
    end

    gap_d = gap_q;
    if ((state_q != ST_GAP) || rise) begin
      gap_d = '0;
    end else if (gap_tick) begin
      gap_d = gap_q + GW'(1);
    end

    cnt_d  = cnt_q;
    bits_d = bits_q;
    ovf_d  = ovf_q;
    if (reach) begin
      cnt_d  = 3'd0;
      bits_d = 5'd0;
      ovf_d  = 1'b0;
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        if (cnt_q == 3'(i)) begin
          bits_d[i] = press_dash;
        end
      end
      cnt_d = cnt_q + 3'd1;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      gap_q  <= '0;
      cnt_q  <= 3'd0;
      bits_q <= 5'd0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
      bits_q <= bits_d;
      ovf_q  <= ovf_d;
    end
  end

  // Registered outputs: symbol/letter strobes and the held letter fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid_q <= 1'b0;
      sym_dash_q  <= 1'b0;
      let_valid_q <= 1'b0;
      let_len_q   <= 3'd0;
      let_bits_q  <= 5'd0;
      let_ovf_q   <= 1'b0;
    end else begin
      sym_valid_q <= accept;
      if (accept) begin
        sym_dash_q <= press_dash;
      end
      let_valid_q <= reach;
      if (reach) begin
        let_len_q  <= cnt_q;
        let_bits_q <= bits_q;
        let_ovf_q  <= ovf_q;
      end
    end
  end

  assign symbol_valid    = sym_valid_q;
  assign symbol_is_dash  = sym_dash_q;
  assign letter_valid    = let_valid_q;
  assign letter_len      = let_len_q;
  assign letter_bits     = let_bits_q;
  assign letter_overflow = let_ovf_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb/tb_morse_symbol_decoder.sv - self-checking bench for morse_symbol_decoder
module tb_morse_symbol_decoder;
  import morse_pkg::*;

  localparam int DIV   = 10;
  localparam int GAPT  = 20;
  localparam int LAT   = DIV * GAPT;
  localparam int MINP  = 96;
  localparam int DASHT = 2400;
  localparam int MAXS  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] ticks = '0;
  logic        symbol_valid;
  logic        symbol_is_dash;
  logic        letter_valid;
  logic [2:0]  letter_len;
  logic [4:0]  letter_bits;
  logic        letter_overflow;

  morse_symbol_decoder #(
    .CLK_F           (1000),
    .TICK_RATE       (100),
    .MIN_PRESS_TICKS (MINP),
    .DASH_TICKS      (DASHT),
    .GAP_TICKS       (GAPT),
    .MAX_SYMBOLS     (MAXS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ticks           (ticks),
    .symbol_valid    (symbol_valid),
    .symbol_is_dash  (symbol_is_dash),
    .letter_valid    (letter_valid),
    .letter_len      (letter_len),
    .letter_bits     (letter_bits),
    .letter_overflow (letter_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the letter under construction as a plain symbol list.
  int   m_len = 0;
  bit   m_sym[5];
  bit   m_ovf = 0;
  int   last_sym_cyc = 0;
  bit   lat_valid = 0;
  int   prev_len = 0;
  int   prev_bits = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_bits();
    int b = 0;
    for (int i = 0; i < m_len; i++) if (m_sym[i]) b += (1 << i);
    return b;
  endfunction

  task automatic model_clear();
    m_len = 0;
    m_ovf = 0;
    for (int i = 0; i < 5; i++) m_sym[i] = 0;
  endtask

  task automatic begin_press();
    start = 1'b1;
    ticks = '0;
  endtask

  // Completes a press already begun: the generator count appears, start
  // drops, and one cycle later the count returns to zero.
  task automatic finish_press(input int t);
    int pulses;
    logic seen_dash;
    bit exp_acc;
    bit exp_dash;
    repeat (2) @(negedge clk);
    ticks = 17'(t);
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ticks = '0;
    exp_acc = 0;
    exp_dash = (t >= DASHT);
    if (t >= MINP) begin
      if (m_len < MAXS) begin
        m_sym[m_len] = exp_dash;
        m_len++;
        exp_acc = 1;
      end else begin
        m_ovf = 1;
      end
    end
    pulses = 0;
    seen_dash = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (symbol_valid) begin
        pulses++;
        seen_dash = symbol_is_dash;
        last_sym_cyc = cyc;
      end
    end
    chk($sformatf("sym_count_t%0d", t), pulses, exp_acc);
    if (exp_acc) chk($sformatf("sym_dash_t%0d", t), seen_dash, exp_dash);
    lat_valid = exp_acc;
  endtask

  task automatic press(input int t);
    @(negedge clk);
    begin_press();
    finish_press(t);
  endtask

  task automatic expect_letter(input string tag);
    bit got;
    int lc;
    int d;
    got = 0;
    lc = 0;
    for (int i = 0; i < LAT + 20 && !got; i++) begin
      @(negedge clk);
      if (letter_valid) begin
        got = 1;
        lc = cyc;
      end
    end
    chk({tag, "_seen"}, got, 1);
    if (got) begin
      chk({tag, "_len"}, letter_len, m_len);
      chk({tag, "_bits"}, letter_bits, model_bits());
      chk({tag, "_ovf"}, letter_overflow, m_ovf);
      if (lat_valid) begin
        d = lc - last_sym_cyc;
        chk({tag, "_latency_ok"}, (d >= LAT - 1 && d <= LAT + 1), 1);
      end
      @(negedge clk);
      chk({tag, "_pulse_end"}, letter_valid, 0);
    end
    prev_len = m_len;
    prev_bits = model_bits();
    model_clear();
    lat_valid = 0;
  endtask

  task automatic expect_no_letter(input string tag, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (letter_valid) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sv"}, symbol_valid, 0);
    chk({tag, "_sd"}, symbol_is_dash, 0);
    chk({tag, "_lv"}, letter_valid, 0);
    chk({tag, "_len"}, letter_len, 0);
    chk({tag, "_bits"}, letter_bits, 0);
    chk({tag, "_ovf"}, letter_overflow, 0);
  endtask

  initial begin
    int np;
    int t;
    int k;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single dot -> "E"
    press(960);
    expect_letter("dot_E");

    // Dash boundary 2399 (dot) then 2400 (dash) -> "A"
    press(2399);
    press(2400);
    expect_letter("dash_bound_A");

    // Glitch from IDLE: nothing emitted, letter outputs keep the last letter
    press(50);
    expect_no_letter("glitch_no_letter", LAT + 20);
    chk("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("glitch_len_held", letter_len, prev_len);
    chk("glitch_bits_held", letter_bits, prev_bits);

    // Minimum-length boundary and saturated tick count
    press(95);
    press(96);
    press(96000);
    expect_letter("min_sat");

    // Overflow: six dots
    for (int i = 0; i < 6; i++) press(960);
    expect_letter("overflow");

    // Collision: new press lands in the cycle the gap closes
    press(3000);
    while (cyc != last_sym_cyc + LAT - 3) @(negedge clk);
    begin_press();
    got = 0;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (letter_valid) begin
        got = 1;
        k = cyc;
      end
    end
    chk("coll_seen", got, 1);
    chk("coll_len", letter_len, m_len);
    chk("coll_bits", letter_bits, model_bits());
    chk("coll_latency_ok", (k - last_sym_cyc >= LAT - 1 && k - last_sym_cyc <= LAT + 1), 1);
    chk("coll_state_press", 32'(dut.state_q), 32'(ST_PRESS));
    model_clear();
    finish_press(960);
    expect_letter("coll_next");

    // Reset mid-letter with three symbols pending
    press(960);
    press(3000);
    press(960);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    model_clear();
    lat_valid = 0;
    expect_no_letter("midreset_no_letter", LAT + 40);
    chk("midreset_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Randomized letters
    for (int l = 0; l < 6; l++) begin
      np = $urandom_range(1, 7);
      for (int p = 0; p < np; p++) begin
        k = $urandom_range(0, 3);
        if (k == 0)      t = $urandom_range(1, MINP - 1);
        else if (k == 1) t = $urandom_range(MINP, DASHT - 1);
        else             t = $urandom_range(DASHT, 96000);
        press(t);
      end
      if (m_len == 0) begin
        expect_no_letter($sformatf("rand%0d_none", l), LAT + 20);
      end else begin
        expect_letter($sformatf("rand%0d", l));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
